// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the memory-access pipeline stage: control-bus layout,
// access-size codes, FSM states and the alignment rule.
package mem_access_stage_pkg;

    localparam int MEM_CTRL_SIZE   = 7;
    localparam int WB_CTRL_SIZE    = 2;
    localparam int TIMEOUT_DEFAULT = 255;

    // Bit positions inside p_MEM_MEM_Ctrl_Bus (LSB first).
    localparam int MC_MEM_READ  = 0;
    localparam int MC_MEM_WRITE = 1;
    localparam int MC_BRANCH    = 2;
    localparam int MC_SIZE_LO   = 3;
    localparam int MC_UNSIGNED  = 6;

    typedef enum logic [2:0] {
        SZ_B = 3'd0,
        SZ_H = 3'd1,
        SZ_W = 3'd2,
        SZ_D = 3'd3
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    // Packed view of the MEM control bus; field order matches the MC_* positions.
    typedef struct packed {
        logic       unsigned_ld;
        logic [2:0] size;
        logic       branch;
        logic       mem_write;
        logic       mem_read;
    } mem_ctrl_t;

    // Size codes outside B/H/W/D count as misaligned so they never reach memory.
    function automatic logic is_aligned(input logic [2:0] size, input logic [2:0] offset);
        case (size)
            SZ_B:    is_aligned = 1'b1;
            SZ_H:    is_aligned = (offset[0] == 1'b0);
            SZ_W:    is_aligned = (offset[1:0] == 2'b00);
            SZ_D:    is_aligned = (offset == 3'b000);
            default: is_aligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_stage_lane_align.sv
// mem_lane_align: byte-lane steering for stores (data and byte enables) and
// extraction plus sign/zero extension for loads. Purely combinational.
module mem_lane_align
    import mem_access_stage_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [2:0]       offset,
    input  logic [2:0]       size,
    input  logic             unsigned_ld,
    input  logic [WIDTH-1:0] store_data,
    input  logic [WIDTH-1:0] read_data,
    output logic [WIDTH-1:0] lane_wdata,
    output logic [7:0]       lane_be,
    output logic [WIDTH-1:0] load_data
);

    logic [5:0]       bit_shift;
    logic [WIDTH-1:0] shifted;
    logic             sign_bit;

    assign bit_shift  = {offset, 3'b000};
    assign lane_wdata = store_data << bit_shift;
    assign shifted    = read_data >> bit_shift;

    always_comb begin
        lane_be = 8'h00;
        case (size)
            SZ_B:    lane_be = 8'h01 << offset;
            SZ_H:    lane_be = 8'h03 << offset;
            SZ_W:    lane_be = 8'h0F << offset;
            SZ_D:    lane_be = 8'hFF;
            default: lane_be = 8'h00;
        endcase
    end

    // Doubleword loads fill the register, so the unsigned flag has nothing to act on.
    always_comb begin
        sign_bit  = 1'b0;
        load_data = shifted;
        case (size)
            SZ_B: begin
                sign_bit  = ~unsigned_ld & shifted[7];
                load_data = {{(WIDTH-8){sign_bit}}, shifted[7:0]};
            end
            SZ_H: begin
                sign_bit  = ~unsigned_ld & shifted[15];
                load_data = {{(WIDTH-16){sign_bit}}, shifted[15:0]};
            end
            SZ_W: begin
                sign_bit  = ~unsigned_ld & shifted[31];
                load_data = {{(WIDTH-32){sign_bit}}, shifted[31:0]};
            end
            default: load_data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues aligned loads/stores to data memory through an
// IDLE/ACCESS/DONE handshake, stalls upstream while waiting, and flags errors.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int WIDTH   = 64,
    parameter int ADDR    = 5,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                     p_clk,
    input  logic                     p_reset_l,
    input  logic [WIDTH-1:0]         p_MEM_BranchAddress,
    input  logic [WIDTH-1:0]         p_MEM_ALUResult,
    input  logic [WIDTH-1:0]         p_MEM_WriteOut,
    input  logic [ADDR-1:0]          p_MEM_RegDest,
    input  logic [WB_CTRL_SIZE-1:0]  p_MEM_WB_Ctrl_Bus,
    input  logic                     p_MEM_ALUZero,
    input  logic [MEM_CTRL_SIZE-1:0] p_MEM_MEM_Ctrl_Bus,
    output logic                     p_DM_Req,
    output logic                     p_DM_We,
    output logic [WIDTH-1:0]         p_DM_Addr,
    output logic [WIDTH-1:0]         p_DM_WData,
    output logic [7:0]               p_DM_BE,
    input  logic                     p_DM_Ack,
    input  logic [WIDTH-1:0]         p_DM_RData,
    output logic [WIDTH-1:0]         p_WB_ReadData,
    output logic [WIDTH-1:0]         p_WB_ALUResult,
    output logic [ADDR-1:0]          p_WB_RegDest,
    output logic [WB_CTRL_SIZE-1:0]  p_WB_Ctrl_Bus,
    output logic                     p_MEM_Stall,
    output logic                     p_PCSrc,
    output logic [WIDTH-1:0]         p_PC_BranchTarget,
    output logic                     p_MEM_AlignErr,
    output logic                     p_MEM_BusErr
);

    localparam int                CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT);

    mem_ctrl_t        ctrl;
    logic [2:0]       offset;
    logic             any_mem;
    logic             access_op;
    logic             aligned_op;
    logic             bad_op;
    state_e           state;
    state_e           state_next;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_inc;
    logic             timeout_hit;
    logic [WIDTH-1:0] load_data;

    assign ctrl   = mem_ctrl_t'(p_MEM_MEM_Ctrl_Bus);
    assign offset = p_MEM_ALUResult[2:0];

    // Read-and-write together is not a legal op; it lands in bad_op with misaligned ones.
    assign any_mem    = ctrl.mem_read | ctrl.mem_write;
    assign access_op  = ctrl.mem_read ^ ctrl.mem_write;
    assign aligned_op = access_op & is_aligned(ctrl.size, offset);
    assign bad_op     = any_mem & ~aligned_op;

    assign wait_cnt_inc = (wait_cnt == CNT_MAX) ? CNT_MAX : wait_cnt + 1'b1;
    assign timeout_hit  = ~p_DM_Ack & (wait_cnt_inc == CNT_MAX);

    mem_lane_align #(
        .WIDTH(WIDTH)
    ) u_lane_align (
        .offset      (offset),
        .size        (ctrl.size),
        .unsigned_ld (ctrl.unsigned_ld),
        .store_data  (p_MEM_WriteOut),
        .read_data   (p_DM_RData),
        .lane_wdata  (p_DM_WData),
        .lane_be     (p_DM_BE),
        .load_data   (load_data)
    );

    always_ff @(posedge p_clk or negedge p_reset_l) begin
        // NOTE: state registers take non-blocking assignments so every flop samples pre-edge values.
        if (!p_reset_l) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: defaults come first so no branch of the case can infer a latch.
        state_next  = state;
        p_MEM_Stall = 1'b0;
        p_DM_Req    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (aligned_op) begin
                    p_MEM_Stall = 1'b1;
                    state_next  = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                p_MEM_Stall = 1'b1;
                p_DM_Req    = 1'b1;
                if (p_DM_Ack || timeout_hit) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Held at zero outside ACCESS, so it starts from zero on every entry.
    always_ff @(posedge p_clk or negedge p_reset_l) begin
        if (!p_reset_l) begin
            wait_cnt <= '0;
        end else if (state == ST_ACCESS) begin
            wait_cnt <= wait_cnt_inc;
        end else begin
            wait_cnt <= '0;
        end
    end

    always_ff @(posedge p_clk or negedge p_reset_l) begin
        if (!p_reset_l) begin
            p_WB_ReadData  <= '0;
            p_MEM_BusErr   <= 1'b0;
            p_MEM_AlignErr <= 1'b0;
        end else begin
            p_MEM_BusErr   <= (state == ST_ACCESS) & timeout_hit;
            p_MEM_AlignErr <= (state == ST_IDLE) & bad_op;
            if (state == ST_ACCESS) begin
                if (p_DM_Ack) begin
                    if (ctrl.mem_read) begin
                        p_WB_ReadData <= load_data;
                    end
                end else if (timeout_hit) begin
                    p_WB_ReadData <= '0;
                end
            end
        end
    end

    assign p_DM_Addr = {p_MEM_ALUResult[WIDTH-1:3], 3'b000};
    assign p_DM_We   = ctrl.mem_write;

    // A faulting op retires with its write-back suppressed: misaligned ones in
    // their IDLE cycle, timed-out ones in DONE.
    assign p_WB_Ctrl_Bus = (((state == ST_IDLE) && bad_op) || ((state == ST_DONE) && p_MEM_BusErr))
                           ? '0 : p_MEM_WB_Ctrl_Bus;

    assign p_WB_ALUResult    = p_MEM_ALUResult;
    assign p_WB_RegDest      = p_MEM_RegDest;
    assign p_PCSrc           = ctrl.branch & p_MEM_ALUZero;
    assign p_PC_BranchTarget = p_MEM_BranchAddress;

endmodule
